// File: rtl/firengine_pkg.sv
// Shared FIR engine constants and types used by the sample clock generator.
package firengine_pkg;

   localparam int CLOCK_CONFIG_WIDTH = 4;
   localparam int HALF_PERIOD_UNIT   = 4;
   localparam int BITS_PER_FRAME     = 32;

   typedef logic [CLOCK_CONFIG_WIDTH-1:0] clock_config_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } clkgen_state_e;

endpackage

// File: rtl/sample_clock_gen.sv
// Sample-rate timing for the FIR engine: frame strobe, 50%-duty bit clock,
// edge strobes, bit index and frame sync. The rate select is shadowed and
// only reloaded at frame boundaries so frames are never cut short or stretched.
module sample_clock_gen
   import firengine_pkg::*;
#(
   parameter int ClockConfigWidth = CLOCK_CONFIG_WIDTH,
   parameter int HalfPeriodUnit   = HALF_PERIOD_UNIT,
   parameter int BitsPerFrame     = BITS_PER_FRAME
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [ClockConfigWidth-1:0]     clockConfig,
   output logic                            sampleStrobe,
   output logic                            bitClk,
   output logic                            bitClkRise,
   output logic                            bitClkFall,
   output logic [$clog2(BitsPerFrame)-1:0] bitIndex,
   output logic                            frameSync
);

   localparam int UnitBits = $clog2(HalfPeriodUnit);
   localparam int HalfW    = ClockConfigWidth + UnitBits + 1;
   localparam int IndexW   = $clog2(BitsPerFrame);
   localparam int HalfCntW = IndexW + 1;

   clkgen_state_e               state;
   clkgen_state_e               stateNext;
   logic [ClockConfigWidth-1:0] cfgQ;
   logic [HalfW-1:0]            halfPeriod;
   logic [HalfW-1:0]            phaseCnt;
   logic [HalfCntW-1:0]         halfCnt;
   logic                        firstFrame;
   logic                        phaseZero;
   logic                        phaseEnd;
   logic                        frameEnd;

   // Half-period length in clk cycles; the extra MSB keeps cfg max from overflowing.
   assign halfPeriod = (HalfW'(cfgQ) + HalfW'(1)) * HalfW'(HalfPeriodUnit);
   assign phaseZero  = (phaseCnt == '0);
   assign phaseEnd   = (phaseCnt == halfPeriod - HalfW'(1));
   assign frameEnd   = phaseEnd && (halfCnt == '1);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Phase/half-period counters and the frame-aligned shadow of the rate select.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfgQ       <= '0;
         phaseCnt   <= '0;
         halfCnt    <= '0;
         firstFrame <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               phaseCnt <= '0;
               halfCnt  <= '0;
               if (enable) begin
                  cfgQ       <= clockConfig;
                  firstFrame <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  // Abort immediately: no frame completion and no reload.
                  phaseCnt   <= '0;
                  halfCnt    <= '0;
                  firstFrame <= 1'b0;
               end else if (phaseEnd) begin
                  phaseCnt <= '0;
                  halfCnt  <= halfCnt + HalfCntW'(1);
                  if (frameEnd) begin
                     cfgQ       <= clockConfig;
                     firstFrame <= 1'b0;
                  end
               end else begin
                  phaseCnt <= phaseCnt + HalfW'(1);
               end
            end
            default: begin
               phaseCnt <= '0;
               halfCnt  <= '0;
            end
         endcase
      end
   end

   // Next state and output decode; outputs are forced low outside RUN.
   always_comb begin
      stateNext    = state;
      sampleStrobe = 1'b0;
      bitClk       = 1'b0;
      bitClkRise   = 1'b0;
      bitClkFall   = 1'b0;
      bitIndex     = '0;
      frameSync    = 1'b0;
      case (state)
         IDLE: begin
            if (enable) stateNext = RUN;
         end
         RUN: begin
            if (!enable) stateNext = IDLE;
            sampleStrobe = phaseZero && (halfCnt == '0);
            bitClk       = halfCnt[0];
            bitClkRise   = phaseZero && halfCnt[0];
            // The very first half-period after entering RUN has no preceding high phase.
            bitClkFall   = phaseZero && !halfCnt[0] && ((halfCnt != '0) || !firstFrame);
            bitIndex     = halfCnt[HalfCntW-1:1];
            frameSync    = (halfCnt[HalfCntW-1:1] == '0);
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule
